// File: rtl/seg7_disp_arb_if.sv
// Bundle between the display clients and the seven-segment arbiter.
//
// Handshake: a client holds req[i] high for as long as it wants the display;
// the arbiter answers with a one-hot gnt. While gnt[i] is high, disp_valid is
// high and disp_dat follows dat<i> whenever req[i] is high. The client must
// not assume the grant ends when it drops req: it ends only when rel pulses
// with rel_id == i, after which gnt and disp_valid are low for at least one
// cycle.
interface seg7_disp_arb_if;
    logic [2:0]  req;
    logic [15:0] dat0;
    logic [15:0] dat1;
    logic [15:0] dat2;
    logic [2:0]  gnt;
    logic [15:0] disp_dat;
    logic        disp_valid;
    logic        rel;
    logic [1:0]  rel_id;
    logic        dbg_state;   // 0 = IDLE, 1 = SHOW

    // Client / scan-driver side
    modport master (
        output req, dat0, dat1, dat2,
        input  gnt, disp_dat, disp_valid, rel, rel_id, dbg_state
    );

    // Arbiter side
    modport slave (
        input  req, dat0, dat1, dat2,
        output gnt, disp_dat, disp_valid, rel, rel_id, dbg_state
    );
endinterface

// File: rtl/seg7_disp_arb.sv
// Round-robin owner selection for the shared 4-digit seven-segment display.
// A granted client keeps the display for at least HOLD_CYC cycles so the
// value is readable; after that it is released as soon as it stops asking
// or another client is waiting.
module seg7_disp_arb #(
    parameter int          HOLD_CYC = 100_000_000,
    parameter int          CNT_W    = 27,
    parameter logic [15:0] IDLE_PAT = 16'h0000
) (
    input  logic             clk,
    input  logic             rst,
    seg7_disp_arb_if.slave   bus
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SHOW = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(HOLD_CYC - 1);

    state_t           state_q,      state_d;
    logic [1:0]       owner_q,      owner_d;
    logic [1:0]       ptr_q,        ptr_d;
    logic [CNT_W-1:0] hold_cnt_q,   hold_cnt_d;
    logic [2:0]       gnt_q,        gnt_d;
    logic [15:0]      disp_dat_q,   disp_dat_d;
    logic             disp_valid_q, disp_valid_d;
    logic             rel_q,        rel_d;
    logic [1:0]       rel_id_q,     rel_id_d;

    logic [1:0]       winner;
    logic [15:0]      owner_dat;
    logic [2:0]       owner_oh;
    logic             owner_req;
    logic             others_req;

    // First requester found searching upward from p+1, wrapping modulo 3.
    function automatic logic [1:0] rr_pick(input logic [2:0] r, input logic [1:0] p);
        logic [1:0] idx;
        rr_pick = 2'd0;
        for (int i = 3; i >= 1; i--) begin
            idx = 2'((int'(p) + i) % 3);
            if (r[idx]) rr_pick = idx;
        end
    endfunction

    function automatic logic [2:0] onehot3(input logic [1:0] i);
        onehot3 = 3'b000;
        case (i)
            2'd0:    onehot3 = 3'b001;
            2'd1:    onehot3 = 3'b010;
            2'd2:    onehot3 = 3'b100;
            default: onehot3 = 3'b000;
        endcase
    endfunction

    function automatic logic [15:0] dat_sel(input logic [1:0] i, input logic [15:0] d0,
                                            input logic [15:0] d1, input logic [15:0] d2);
        dat_sel = d0;
        case (i)
            2'd1:    dat_sel = d1;
            2'd2:    dat_sel = d2;
            default: dat_sel = d0;
        endcase
    endfunction

    // Decode of the current owner's request line and of competing requests.
    always_comb begin
        winner     = rr_pick(bus.req, ptr_q);
        owner_oh   = onehot3(owner_q);
        owner_dat  = dat_sel(owner_q, bus.dat0, bus.dat1, bus.dat2);
        owner_req  = |(bus.req & owner_oh);
        others_req = |(bus.req & ~owner_oh);
    end

    // Next-state and next-output computation for the IDLE/SHOW controller.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        ptr_d        = ptr_q;
        hold_cnt_d   = hold_cnt_q;
        gnt_d        = gnt_q;
        disp_dat_d   = disp_dat_q;
        disp_valid_d = disp_valid_q;
        rel_d        = 1'b0;
        rel_id_d     = rel_id_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.req != 3'b000) begin
                    state_d      = ST_SHOW;
                    owner_d      = winner;
                    ptr_d        = winner;
                    hold_cnt_d   = '0;
                    gnt_d        = onehot3(winner);
                    disp_valid_d = 1'b1;
                    disp_dat_d   = dat_sel(winner, bus.dat0, bus.dat1, bus.dat2);
                end
            end
            ST_SHOW: begin
                // Follow the owner's data only while it still asks; otherwise freeze.
                if (owner_req) disp_dat_d = owner_dat;
                if (hold_cnt_q == HOLD_MAX) begin
                    if (!owner_req || others_req) begin
                        state_d      = ST_IDLE;
                        gnt_d        = 3'b000;
                        disp_valid_d = 1'b0;
                        rel_d        = 1'b1;
                        rel_id_d     = owner_q;
                    end
                end else begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and registered outputs; rst clears everything immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            owner_q      <= 2'd0;
            ptr_q        <= 2'd2;
            hold_cnt_q   <= '0;
            gnt_q        <= 3'b000;
            disp_dat_q   <= IDLE_PAT;
            disp_valid_q <= 1'b0;
            rel_q        <= 1'b0;
            rel_id_q     <= 2'd0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            ptr_q        <= ptr_d;
            hold_cnt_q   <= hold_cnt_d;
            gnt_q        <= gnt_d;
            disp_dat_q   <= disp_dat_d;
            disp_valid_q <= disp_valid_d;
            rel_q        <= rel_d;
            rel_id_q     <= rel_id_d;
        end
    end

    assign bus.gnt        = gnt_q;
    assign bus.disp_dat   = disp_dat_q;
    assign bus.disp_valid = disp_valid_q;
    assign bus.rel        = rel_q;
    assign bus.rel_id     = rel_id_q;
    assign bus.dbg_state  = state_q;

endmodule

// File: tb/tb_seg7_disp_arb.sv
// Directed bench for seg7_disp_arb: one instance with a 4-cycle hold and one
// with a 1-cycle hold, each driven through its own interface.
module tb_seg7_disp_arb;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    seg7_disp_arb_if ifa ();
    seg7_disp_arb_if ifb ();

    seg7_disp_arb #(.HOLD_CYC(4), .CNT_W(27), .IDLE_PAT(16'h0000)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (ifa.slave)
    );

    seg7_disp_arb #(.HOLD_CYC(1), .CNT_W(4), .IDLE_PAT(16'h0000)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (ifb.slave)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        ifa.req  = 3'b000;
        ifb.req  = 3'b000;
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b0;
    endtask

    // Packed view used for compact checks: {gnt, disp_valid, rel, rel_id}
    function automatic logic [6:0] ctl_a();
        return {ifa.gnt, ifa.disp_valid, ifa.rel, ifa.rel_id};
    endfunction

    function automatic logic [6:0] ctl_b();
        return {ifb.gnt, ifb.disp_valid, ifb.rel, ifb.rel_id};
    endfunction

    task automatic test_reset();
        do_reset();
        n_checks++;
        if (ctl_a() !== 7'b000_0_0_00) begin
            n_fail++;
            $display("FAIL reset_ctl_a: got %b expected %b", ctl_a(), 7'b000_0_0_00);
        end
        n_checks++;
        if (ifa.disp_dat !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_dat_a: got %h expected %h", ifa.disp_dat, 16'h0000);
        end
        n_checks++;
        if (ifa.dbg_state !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state_a: got %b expected %b", ifa.dbg_state, 1'b0);
        end
        n_checks++;
        if ({ctl_b(), ifb.disp_dat} !== {7'b000_0_0_00, 16'h0000}) begin
            n_fail++;
            $display("FAIL reset_b: got %h expected %h", {ctl_b(), ifb.disp_dat}, {7'b0, 16'h0000});
        end
    endtask

    task automatic test_single_owner();
        do_reset();
        ifa.dat0 = 16'h1234;
        ifa.req  = 3'b001;
        step();
        n_checks++;
        if ({ctl_a(), ifa.disp_dat} !== {7'b001_1_0_00, 16'h1234}) begin
            n_fail++;
            $display("FAIL single_grant: got %h expected %h", {ctl_a(), ifa.disp_dat}, {7'b001_1_0_00, 16'h1234});
        end
        n_checks++;
        if (ifa.dbg_state !== 1'b1) begin
            n_fail++;
            $display("FAIL single_state: got %b expected %b", ifa.dbg_state, 1'b1);
        end
        ifa.dat0 = 16'hBEEF;
        step();
        n_checks++;
        if (ifa.disp_dat !== 16'hBEEF) begin
            n_fail++;
            $display("FAIL single_track: got %h expected %h", ifa.disp_dat, 16'hBEEF);
        end
        for (int i = 0; i < 10; i++) begin
            step();
            n_checks++;
            if (ctl_a() !== 7'b001_1_0_00) begin
                n_fail++;
                $display("FAIL single_persist[%0d]: got %b expected %b", i, ctl_a(), 7'b001_1_0_00);
            end
        end
        // Owner stops asking; hold already expired so release is immediate.
        ifa.req = 3'b000;
        step();
        n_checks++;
        if ({ctl_a(), ifa.disp_dat} !== {7'b000_0_1_00, 16'hBEEF}) begin
            n_fail++;
            $display("FAIL single_release: got %h expected %h", {ctl_a(), ifa.disp_dat}, {7'b000_0_1_00, 16'hBEEF});
        end
        step();
        n_checks++;
        if ({ctl_a(), ifa.disp_dat} !== {7'b000_0_0_00, 16'hBEEF}) begin
            n_fail++;
            $display("FAIL single_idle: got %h expected %h", {ctl_a(), ifa.disp_dat}, {7'b000_0_0_00, 16'hBEEF});
        end
    endtask

    task automatic test_round_robin();
        logic [2:0] exp_oh [4];
        logic [1:0] exp_id [4];
        exp_oh = '{3'b001, 3'b010, 3'b100, 3'b001};
        exp_id = '{2'd0, 2'd1, 2'd2, 2'd0};
        do_reset();
        ifa.dat0 = 16'h0A0A;
        ifa.dat1 = 16'h1B1B;
        ifa.dat2 = 16'h2C2C;
        ifa.req  = 3'b111;
        for (int g = 0; g < 4; g++) begin
            for (int c = 0; c < 4; c++) begin
                step();
                n_checks++;
                if (ifa.gnt !== exp_oh[g] || ifa.disp_valid !== 1'b1 || ifa.rel !== 1'b0) begin
                    n_fail++;
                    $display("FAIL rr_hold[%0d.%0d]: got %b expected gnt %b valid 1 rel 0", g, c, ctl_a(), exp_oh[g]);
                end
            end
            step();
            n_checks++;
            if (ctl_a() !== {3'b000, 1'b0, 1'b1, exp_id[g]}) begin
                n_fail++;
                $display("FAIL rr_gap[%0d]: got %b expected %b", g, ctl_a(), {3'b000, 1'b0, 1'b1, exp_id[g]});
            end
        end
    endtask

    task automatic test_drop_mid_hold();
        do_reset();
        ifa.dat1 = 16'hAAAA;
        ifa.req  = 3'b010;
        step();
        n_checks++;
        if ({ifa.gnt, ifa.disp_dat} !== {3'b010, 16'hAAAA}) begin
            n_fail++;
            $display("FAIL drop_grant: got %h expected %h", {ifa.gnt, ifa.disp_dat}, {3'b010, 16'hAAAA});
        end
        ifa.req  = 3'b000;
        ifa.dat1 = 16'h5555;
        for (int c = 0; c < 3; c++) begin
            step();
            n_checks++;
            if ({ifa.gnt, ifa.disp_dat} !== {3'b010, 16'hAAAA}) begin
                n_fail++;
                $display("FAIL drop_hold[%0d]: got %h expected %h", c, {ifa.gnt, ifa.disp_dat}, {3'b010, 16'hAAAA});
            end
        end
        step();
        n_checks++;
        if ({ctl_a(), ifa.disp_dat} !== {7'b000_0_1_01, 16'hAAAA}) begin
            n_fail++;
            $display("FAIL drop_release: got %h expected %h", {ctl_a(), ifa.disp_dat}, {7'b000_0_1_01, 16'hAAAA});
        end
        step();
        n_checks++;
        if ({ctl_a(), ifa.disp_dat} !== {7'b000_0_0_01, 16'hAAAA}) begin
            n_fail++;
            $display("FAIL drop_idle: got %h expected %h", {ctl_a(), ifa.disp_dat}, {7'b000_0_0_01, 16'hAAAA});
        end
    endtask

    task automatic test_preempt();
        do_reset();
        ifa.dat0 = 16'h0F0F;
        ifa.dat2 = 16'hC0DE;
        ifa.req  = 3'b100;
        step();
        n_checks++;
        if ({ifa.gnt, ifa.disp_dat} !== {3'b100, 16'hC0DE}) begin
            n_fail++;
            $display("FAIL preempt_grant: got %h expected %h", {ifa.gnt, ifa.disp_dat}, {3'b100, 16'hC0DE});
        end
        ifa.req = 3'b101;
        for (int c = 0; c < 3; c++) begin
            step();
            n_checks++;
            if (ifa.gnt !== 3'b100) begin
                n_fail++;
                $display("FAIL preempt_hold[%0d]: got %b expected %b", c, ifa.gnt, 3'b100);
            end
        end
        step();
        n_checks++;
        if (ctl_a() !== 7'b000_0_1_10) begin
            n_fail++;
            $display("FAIL preempt_release: got %b expected %b", ctl_a(), 7'b000_0_1_10);
        end
        step();
        n_checks++;
        if ({ctl_a(), ifa.disp_dat} !== {7'b001_1_0_10, 16'h0F0F}) begin
            n_fail++;
            $display("FAIL preempt_next: got %h expected %h", {ctl_a(), ifa.disp_dat}, {7'b001_1_0_10, 16'h0F0F});
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        ifa.dat2 = 16'h7777;
        ifa.req  = 3'b100;
        step();
        step();
        n_checks++;
        if (ifa.gnt !== 3'b100) begin
            n_fail++;
            $display("FAIL areset_pre: got %b expected %b", ifa.gnt, 3'b100);
        end
        // Assert reset between clock edges and look before the next edge.
        rst = 1'b1;
        #1;
        n_checks++;
        if ({ifa.gnt, ifa.disp_valid, ifa.disp_dat} !== {3'b000, 1'b0, 16'h0000}) begin
            n_fail++;
            $display("FAIL areset_now: got %h expected %h", {ifa.gnt, ifa.disp_valid, ifa.disp_dat}, 20'h0);
        end
        #1;
        rst     = 1'b0;
        ifa.dat1 = 16'h1111;
        ifa.dat2 = 16'h2222;
        ifa.req  = 3'b110;
        step();
        n_checks++;
        if ({ifa.gnt, ifa.disp_dat} !== {3'b010, 16'h1111}) begin
            n_fail++;
            $display("FAIL areset_first: got %h expected %h", {ifa.gnt, ifa.disp_dat}, {3'b010, 16'h1111});
        end
    endtask

    task automatic test_hold1();
        do_reset();
        ifb.dat0 = 16'hD000;
        ifb.dat1 = 16'hD001;
        ifb.req  = 3'b011;
        for (int r = 0; r < 3; r++) begin
            step();
            n_checks++;
            if ({ctl_b(), ifb.disp_dat} !== {3'b001, 1'b1, 1'b0, (r == 0) ? 2'd0 : 2'd1, 16'hD000}) begin
                n_fail++;
                $display("FAIL hold1_g0[%0d]: got %h", r, {ctl_b(), ifb.disp_dat});
            end
            step();
            n_checks++;
            if (ctl_b() !== 7'b000_0_1_00) begin
                n_fail++;
                $display("FAIL hold1_gap0[%0d]: got %b expected %b", r, ctl_b(), 7'b000_0_1_00);
            end
            step();
            n_checks++;
            if ({ctl_b(), ifb.disp_dat} !== {7'b010_1_0_00, 16'hD001}) begin
                n_fail++;
                $display("FAIL hold1_g1[%0d]: got %h expected %h", r, {ctl_b(), ifb.disp_dat}, {7'b010_1_0_00, 16'hD001});
            end
            step();
            n_checks++;
            if (ctl_b() !== 7'b000_0_1_01) begin
                n_fail++;
                $display("FAIL hold1_gap1[%0d]: got %b expected %b", r, ctl_b(), 7'b000_0_1_01);
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        ifa.req  = 3'b000;
        ifa.dat0 = 16'h0000;
        ifa.dat1 = 16'h0000;
        ifa.dat2 = 16'h0000;
        ifb.req  = 3'b000;
        ifb.dat0 = 16'h0000;
        ifb.dat1 = 16'h0000;
        ifb.dat2 = 16'h0000;

        test_reset();
        test_single_owner();
        test_round_robin();
        test_drop_mid_hold();
        test_preempt();
        test_async_reset();
        test_hold1();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seg7_disp_arb.md
# seg7_disp_arb

Round-robin arbiter that shares the board's single 4-digit seven-segment display between three requesters (e.g. CPU register view, PC/status view, debug counter). It grants one requester at a time, enforces a minimum on-screen hold time so values remain readable, and drives the 16-bit hex word consumed by the seven-segment scan driver. It sits between the processor-side sources and the scan driver.

## Interface
- HOLD_CYC, 100_000_000: minimum clk cycles a grant is held (1 s at 100 MHz); legal range 1..2^CNT_W-1.
- CNT_W, 27: hold counter width.
- IDLE_PAT, 16'h0000: value on disp_dat after reset, before any grant.
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- req  in  3  request per client; level-held while the client wants the display.
- dat0, dat1, dat2  in  16 each  4-nibble hex value from client 0/1/2.
- gnt  out  3  one-hot grant; all zero when no owner.
- disp_dat  out  16  word to the scan driver.
- disp_valid  out  1  high while any client owns the display.
- rel  out  1  one-cycle pulse when a grant ends.
- rel_id  out  2  index of the released client, valid with rel.

## Operation
- States: IDLE (no owner), SHOW (owner holds display).
- Reset values: state IDLE, gnt 0, disp_valid 0, rel 0, rel_id 0, disp_dat IDLE_PAT, hold_cnt 0, rr pointer 2 (so client 0 wins the first arbitration).
- IDLE: if req != 0, pick the first set bit searching from ptr+1 upward, modulo 3; set gnt, owner, and ptr to the winner; clear hold_cnt; go to SHOW. If req == 0, stay; disp_dat keeps its last value.
- SHOW: hold_cnt increments each cycle and saturates at HOLD_CYC-1. disp_dat <= dat[owner] on every cycle where req[owner] is high. While req[owner] is low, disp_dat is frozen.
- Release condition, evaluated only when hold_cnt == HOLD_CYC-1: req[owner] is low, or any other req bit is high (fair preemption). On release: clear gnt and disp_valid, pulse rel with rel_id = owner, and go to IDLE.
- If the owner keeps requesting and no other client requests, the grant persists indefinitely.
- A client dropping req before the hold expires does not shorten the hold.
- disp_dat is never forced back to IDLE_PAT except by rst.

## Timing
- All outputs are registered. rst clears everything immediately and asynchronously, including mid-hold; the first grant after reset follows normal IDLE rules.
- req seen in IDLE at cycle t: gnt and disp_valid high at t+1, with disp_dat = dat[winner] sampled at t.
- Data tracking during SHOW: dat[owner] at cycle k appears on disp_dat at k+1.
- Grant length: gnt is high for at least HOLD_CYC consecutive cycles. The release decision is taken at the cycle where hold_cnt == HOLD_CYC-1. At the next cycle, gnt = 0 and rel = 1.
- Re-arbitration gap: IDLE lasts at least 1 cycle, so the next grant at the earliest comes 2 cycles after the last owned cycle. gnt is 0 and disp_valid is 0 during the gap.
- With HOLD_CYC = 1, release can be decided on the first SHOW cycle.
- Simultaneous requests in IDLE are resolved by rotating priority only; no client can be granted twice in a row while another is requesting at release time.

## Test plan
- Reset, then req=001, dat0=16'h1234 (HOLD_CYC=4) -> gnt=001 and disp_dat=1234 one cycle later. Changing dat0 to 16'hBEEF -> disp_dat=BEEF next cycle. Grant is held indefinitely while req=001.
- req=111 held constantly, HOLD_CYC=4 -> grant order 0,1,2,0,…. Each gnt lasts exactly 4 cycles, separated by 1 zero-gnt cycle. rel pulses with rel_id 0,1,2 in turn.
- Owner 1 drops req after 1 cycle of a 4-cycle hold, with dat1 then changed -> gnt stays high for 4 cycles, disp_dat frozen at the last sampled value, then rel with rel_id=1, and disp_dat still holds that value in IDLE.
- Client 2 granted alone, client 0 raises req mid-hold -> client 2 is released exactly at hold expiry, and client 0 is granted 2 cycles later.
- rst asserted mid-SHOW -> gnt=0, disp_valid=0, and disp_dat=IDLE_PAT immediately (no clock edge needed). After release of rst, with req=110, client 1 wins first.
- HOLD_CYC=1, req=011 -> grants alternate 0,1 with 1-cycle grants and 1-cycle gaps.
